sw_debounce: RTL and testbench
==============================

SW_DEBOUNCE -- requirements
Module: sw_debounce

Interface
- REQ-001: The block SHALL have parameter WIDTH, default 8, which sets the number of independent switch channels.
- REQ-002: The block SHALL have parameter SYNC_STAGES, default 2, minimum 2, which sets the depth of the input synchronizer flop chain.
- REQ-003: The block SHALL have parameter STABLE_CYCLES, default 100000 (1 ms at 100 MHz), minimum 1, which sets the consecutive cycles a level must hold before it is accepted.
- REQ-004: clk  input  1  single clock (global-buffered board clock); all state SHALL be clocked on its rising edge.
- REQ-005: rst_n  input  1  reset, asynchronous assert, active-low.
- REQ-006: sw_in  input  WIDTH  raw asynchronous switch levels from pads.
- REQ-007: sw_out  output  WIDTH  debounced, synchronous switch levels.
- REQ-008: rise  output  WIDTH  one-cycle pulse per bit when sw_out goes 0->1.
- REQ-009: fall  output  WIDTH  one-cycle pulse per bit when sw_out goes 1->0.

Function
- REQ-010: Each sw_in bit SHALL pass through a SYNC_STAGES-deep flop chain; the last stage is sync_q[i].
- REQ-011: Each bit SHALL own a counter of width $clog2(STABLE_CYCLES+1); the channels SHALL be fully independent.
- REQ-012: On each edge, if sync_q[i] == sw_out[i], then cnt[i] SHALL be cleared to 0.
- REQ-013: On each edge, if sync_q[i] != sw_out[i] and cnt[i] == STABLE_CYCLES-1, then sw_out[i] SHALL be loaded from sync_q[i] and cnt[i] cleared; otherwise cnt[i] SHALL increment.
- REQ-014: Latency: after a sw_in bit changes and holds, sw_out SHALL reflect it exactly on the (SYNC_STAGES+STABLE_CYCLES)-th rising edge after the change.
- REQ-015: A synchronized level that differs from sw_out for fewer than STABLE_CYCLES consecutive edges SHALL leave sw_out unchanged and SHALL zero the counter on return.
- REQ-016: rise[i] SHALL be high for exactly the one cycle in which sw_out[i] has just become 1; fall[i] likewise when sw_out[i] has just become 0.
- REQ-017: rise[i] and fall[i] SHALL never both be high.
- REQ-018: Simultaneous transitions on multiple bits SHALL each produce their own pulses in the same cycle.
- REQ-019: The counter SHALL never exceed STABLE_CYCLES-1; no wrap-around SHALL occur.
- REQ-020: With STABLE_CYCLES = 1, sw_out SHALL equal sync_q delayed by one edge.

Reset
- REQ-021: rst_n low SHALL immediately, without waiting for a clock edge, clear all synchronizer stages, all counters, sw_out, rise and fall to 0.
- REQ-022: Reset asserted mid-count SHALL discard the partial count; no pulse SHALL be emitted during reset.
- REQ-023: After rst_n deasserts with sw_in[i] high, sw_out[i] SHALL rise after SYNC_STAGES+STABLE_CYCLES edges, with a rise[i] pulse.

Configuration
- REQ-024: Macro SW_DEBOUNCE_EDGE_EN defined: the rise/fall pulse logic (one registered copy of previous sw_out) SHALL be compiled in, behaving per REQ-016..REQ-018.
- REQ-025: Macro SW_DEBOUNCE_EDGE_EN undefined: rise and fall ports SHALL remain present but be tied to constant 0, with no edge registers; sw_out behaviour SHALL be identical in both builds.

Verification
(Bench parameters: WIDTH=8, SYNC_STAGES=2, STABLE_CYCLES=4.)
- REQ-026: rst_n=0 with sw_in=8'hFF -> sw_out=0, rise=0, fall=0; release -> sw_out=8'hFF on the 6th edge, rise=8'hFF for one cycle.
- REQ-027: sw_in[0] 0->1 held -> sw_out[0]=1 on the 6th edge, rise[0] one cycle, other bits unchanged.
- REQ-028: sw_in[3] high glitch for 3 cycles -> sw_out[3] stays 0, no pulses; glitch for 4 cycles -> sw_out[3]=1 then, after return to 0 held, back to 0 with fall[3].
- REQ-029: sw_in 8'h00 -> 8'hA5 in one cycle -> sw_out=8'hA5 on the 6th edge, rise=8'hA5 for one cycle, fall=0.
- REQ-030: sw_in[7] toggled every 2 cycles for 100 cycles -> sw_out[7] never changes.
- REQ-031: rst_n pulsed low at edge 4 of a pending change -> outputs 0 asynchronously; full 6-edge latency restarts after release; with SW_DEBOUNCE_EDGE_EN undefined, rise=fall=0 throughout all scenarios.

Source files
------------

// File: rtl/sw_debounce.sv
// sw_debounce: per-channel switch synchronizer and debouncer.
// Each sw_in bit passes through a SYNC_STAGES-deep synchronizer. A level that
// differs from sw_out must hold for STABLE_CYCLES consecutive edges before
// sw_out accepts it.
// Optional macro SW_DEBOUNCE_EDGE_EN: compiles in the registered rise/fall
// pulse logic. Without it, rise and fall are tied to 0.
module sw_debounce #(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned STABLE_CYCLES = 100000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw_in,
  output logic [WIDTH-1:0] sw_out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

  logic [WIDTH-1:0] sync_r [SYNC_STAGES];
  logic [WIDTH-1:0] sync_q;
  logic [CW-1:0]    cnt     [WIDTH];
  logic [CW-1:0]    cnt_nxt [WIDTH];
  logic [WIDTH-1:0] out_nxt;

  assign sync_q = sync_r[SYNC_STAGES-1];

  // Synchronizer chain for the asynchronous pad levels
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < int'(SYNC_STAGES); s++) begin
        sync_r[s] <= '0;
      end
    end else begin
      sync_r[0] <= sw_in;
      for (int s = 1; s < int'(SYNC_STAGES); s++) begin
        sync_r[s] <= sync_r[s-1];
      end
    end
  end

  // Per-channel stability counter and acceptance decision
  always_comb begin
    out_nxt = sw_out;
    for (int i = 0; i < int'(WIDTH); i++) begin
      cnt_nxt[i] = cnt[i];
      if (sync_q[i] == sw_out[i]) begin
        cnt_nxt[i] = '0;
      end else if (cnt[i] == CNT_LAST) begin
        out_nxt[i] = sync_q[i];
        cnt_nxt[i] = '0;
      end else begin
        cnt_nxt[i] = CW'(cnt[i] + 1'b1);
      end
    end
  end

  // Counter and debounced level registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_out <= '0;
      for (int i = 0; i < int'(WIDTH); i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sw_out <= out_nxt;
      for (int i = 0; i < int'(WIDTH); i++) begin
        cnt[i] <= cnt_nxt[i];
      end
    end
  end

`ifdef SW_DEBOUNCE_EDGE_EN
  // Edge pulses registered alongside sw_out so they coincide with its change
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rise <= '0;
      fall <= '0;
    end else begin
      rise <= out_nxt & ~sw_out;
      fall <= ~out_nxt & sw_out;
    end
  end
`else
  assign rise = '0;
  assign fall = '0;
`endif

endmodule

// File: tb/tb_sw_debounce.sv
// Directed bench for sw_debounce with WIDTH=8, SYNC_STAGES=2, STABLE_CYCLES=4.
// Expected edge pulses depend on whether SW_DEBOUNCE_EDGE_EN is defined.
module tb_sw_debounce;

  localparam int unsigned WIDTH = 8;

`ifdef SW_DEBOUNCE_EDGE_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] sw_in;
  logic [WIDTH-1:0] sw_out;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;

  int checks;
  int errors;

  sw_debounce #(
    .WIDTH        (WIDTH),
    .SYNC_STAGES  (2),
    .STABLE_CYCLES(4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sw_in (sw_in),
    .sw_out(sw_out),
    .rise  (rise),
    .fall  (fall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] ep(input logic [WIDTH-1:0] v);
    return EDGE ? v : '0;
  endfunction

  task automatic chk(input string tag, input logic [WIDTH-1:0] obs,
                     input logic [WIDTH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [WIDTH-1:0] o,
                         input logic [WIDTH-1:0] r, input logic [WIDTH-1:0] f);
    chk({tag, ".sw_out"}, sw_out, o);
    chk({tag, ".rise"}, rise, r);
    chk({tag, ".fall"}, fall, f);
  endtask

  // Advance n rising edges, then settle 1 time unit past the last one
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    sw_in  = 8'hFF;

    // Reset with all switches high
    tick(3);
    chk_all("reset", 8'h00, 8'h00, 8'h00);
    rst_n = 1'b1;
    tick(5);
    chk_all("rel_e5", 8'h00, 8'h00, 8'h00);
    tick(1);
    chk_all("rel_e6", 8'hFF, ep(8'hFF), 8'h00);
    tick(1);
    chk_all("rel_e7", 8'hFF, 8'h00, 8'h00);

    // All low, then bit 0 rises alone
    sw_in = 8'h00;
    tick(6);
    chk_all("all_low", 8'h00, 8'h00, ep(8'hFF));
    tick(1);
    sw_in = 8'h01;
    tick(5);
    chk_all("b0_e5", 8'h00, 8'h00, 8'h00);
    tick(1);
    chk_all("b0_e6", 8'h01, ep(8'h01), 8'h00);
    tick(1);
    chk_all("b0_e7", 8'h01, 8'h00, 8'h00);

    // Bit 3 glitch of 3 cycles is rejected
    sw_in = 8'h09;
    tick(3);
    sw_in = 8'h01;
    for (int k = 0; k < 8; k++) begin
      tick(1);
      chk_all("glitch3", 8'h01, 8'h00, 8'h00);
    end

    // Bit 3 held 4 cycles is accepted, then returns low
    sw_in = 8'h09;
    tick(4);
    sw_in = 8'h01;
    tick(1);
    chk_all("g4_e5", 8'h01, 8'h00, 8'h00);
    tick(1);
    chk_all("g4_e6", 8'h09, ep(8'h08), 8'h00);
    tick(3);
    chk_all("g4_e9", 8'h09, 8'h00, 8'h00);
    tick(1);
    chk_all("g4_e10", 8'h01, 8'h00, ep(8'h08));
    tick(1);
    chk_all("g4_e11", 8'h01, 8'h00, 8'h00);

    // Multi-bit simultaneous change
    sw_in = 8'h00;
    tick(8);
    chk("clear", sw_out, 8'h00);
    sw_in = 8'hA5;
    tick(5);
    chk_all("a5_e5", 8'h00, 8'h00, 8'h00);
    tick(1);
    chk_all("a5_e6", 8'hA5, ep(8'hA5), 8'h00);
    tick(1);
    chk_all("a5_e7", 8'hA5, 8'h00, 8'h00);

    // Bit 7 chatter every 2 cycles never settles
    for (int k = 0; k < 50; k++) begin
      sw_in[7] = ~sw_in[7];
      tick(1);
      chk_all("chatter", 8'hA5, 8'h00, 8'h00);
      tick(1);
      chk_all("chatter", 8'hA5, 8'h00, 8'h00);
    end
    tick(6);
    chk_all("chatter_end", 8'hA5, 8'h00, 8'h00);

    // Reset in the middle of a pending change
    sw_in = 8'h5A;
    tick(4);
    rst_n = 1'b0;
    #1;
    chk_all("mid_rst_async", 8'h00, 8'h00, 8'h00);
    tick(2);
    chk_all("mid_rst_hold", 8'h00, 8'h00, 8'h00);
    rst_n = 1'b1;
    tick(5);
    chk_all("rst2_e5", 8'h00, 8'h00, 8'h00);
    tick(1);
    chk_all("rst2_e6", 8'h5A, ep(8'h5A), 8'h00);
    tick(1);
    chk_all("rst2_e7", 8'h5A, 8'h00, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
